uart_cmd_parser: RTL

//   Sits directly downstream of the UART receiver. Takes its byte stream (rx_data qualified by the po_flag pulse) and

---
 rtl/uart_cmd_parser.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns the UART receiver's byte stream into SDRAM read/write
// commands. Frames are 0x55, CMD, ADDR[23:16], ADDR[15:8], ADDR[7:0], L,
// payload (write only, L+1 bytes), CSUM. Write payload is held in a local
// buffer and released for popping only after the checksum matches and the
// command has been accepted.
module uart_cmd_parser #(
  parameter int D_WIDTH     = 8,
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 416_660,
  localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [D_WIDTH-1:0] rx_data,
  input  logic               po_flag,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               cmd_wr,
  output logic [23:0]        cmd_addr,
  output logic [LEN_W-1:0]   cmd_len,
  output logic [D_WIDTH-1:0] wdata,
  output logic               wdata_empty,
  input  logic               wdata_rd,
  output logic               err,
  output logic [2:0]         err_code
);

  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [D_WIDTH-1:0] SYNC_B = D_WIDTH'(8'h55);
  localparam logic [D_WIDTH-1:0] WR_B   = D_WIDTH'(8'hA1);
  localparam logic [D_WIDTH-1:0] RD_B   = D_WIDTH'(8'hA2);

  localparam logic [2:0] E_CMD     = 3'd1;
  localparam logic [2:0] E_LEN     = 3'd2;
  localparam logic [2:0] E_CSUM    = 3'd3;
  localparam logic [2:0] E_TIMEOUT = 3'd4;
  localparam logic [2:0] E_OVERRUN = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR2, S_ADDR1, S_ADDR0, S_LEN, S_DATA, S_CSUM, S_PEND, S_DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic                 wr_q, wr_d;
  logic [23:0]          addr_q, addr_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [D_WIDTH-1:0]   csum_q, csum_d;
  logic [LEN_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 err_q, err_d;
  logic [2:0]           err_code_q, err_code_d;
  logic                 cmd_valid_q;
  logic                 buf_we;
  logic                 in_frame;
  logic                 can_pop;

  logic [MAX_LEN-1:0][D_WIDTH-1:0] buf_q;

  // Gap timer only runs while a frame is being received.
  assign in_frame = (state_q == S_CMD)   || (state_q == S_ADDR2) || (state_q == S_ADDR1) ||
                    (state_q == S_ADDR0) || (state_q == S_LEN)   || (state_q == S_DATA)  ||
                    (state_q == S_CSUM);

  assign can_pop = (state_q == S_DRAIN) && (rd_ptr_q < len_q);

  // Next-state logic: frame parsing, error detection, handshake and drain.
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    len_d      = len_q;
    csum_d     = csum_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    gap_d      = '0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    buf_we     = 1'b0;

    // A byte arriving in the expiry cycle takes priority over the timeout.
    if (in_frame && !po_flag) begin
      gap_d = gap_q + GAP_W'(1);
      if (gap_q == GAP_W'(TIMEOUT_CYC - 1)) begin
        err_d      = 1'b1;
        err_code_d = E_TIMEOUT;
        state_d    = S_IDLE;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (po_flag && rx_data == SYNC_B) state_d = S_CMD;
      end
      S_CMD: begin
        if (po_flag) begin
          if (rx_data == WR_B || rx_data == RD_B) begin
            wr_d    = (rx_data == WR_B);
            csum_d  = rx_data;  // checksum restarts at CMD
            state_d = S_ADDR2;
          end else begin
            err_d      = 1'b1;
            err_code_d = E_CMD;
            state_d    = S_IDLE;
          end
        end
      end
      S_ADDR2: begin
        if (po_flag) begin
          addr_d[23:16] = rx_data;
          csum_d        = csum_q ^ rx_data;
          state_d       = S_ADDR1;
        end
      end
      S_ADDR1: begin
        if (po_flag) begin
          addr_d[15:8] = rx_data;
          csum_d       = csum_q ^ rx_data;
          state_d      = S_ADDR0;
        end
      end
      S_ADDR0: begin
        if (po_flag) begin
          addr_d[7:0] = rx_data;
          csum_d      = csum_q ^ rx_data;
          state_d     = S_LEN;
        end
      end
      S_LEN: begin
        if (po_flag) begin
          if (rx_data >= D_WIDTH'(MAX_LEN)) begin
            err_d      = 1'b1;
            err_code_d = E_LEN;
            state_d    = S_IDLE;
          end else begin
            len_d   = rx_data[LEN_W-1:0] + LEN_W'(1);
            csum_d  = csum_q ^ rx_data;
            state_d = wr_q ? S_DATA : S_CSUM;
          end
        end
      end
      S_DATA: begin
        if (po_flag) begin
          buf_we   = 1'b1;
          csum_d   = csum_q ^ rx_data;
          wr_ptr_d = wr_ptr_q + LEN_W'(1);
          if (wr_ptr_q + LEN_W'(1) == len_q) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (po_flag) begin
          if (rx_data == csum_q) begin
            state_d = S_PEND;
          end else begin
            err_d      = 1'b1;
            err_code_d = E_CSUM;
            state_d    = S_IDLE;
          end
        end
      end
      S_PEND: begin
        // Bytes arriving now are dropped; the held command is untouched.
        if (po_flag) begin
          err_d      = 1'b1;
          err_code_d = E_OVERRUN;
        end
        if (cmd_ready) state_d = wr_q ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (po_flag) begin
          err_d      = 1'b1;
          err_code_d = E_OVERRUN;
        end
        if (wdata_rd && can_pop) begin
          rd_ptr_d = rd_ptr_q + LEN_W'(1);
          if (rd_ptr_q + LEN_W'(1) == len_q) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Leaving for IDLE by any path discards the buffer contents.
    if (state_d == S_IDLE) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Control and command registers; reset aborts any frame or drain silently.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      csum_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      gap_q       <= '0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      csum_q      <= csum_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      gap_q       <= gap_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      cmd_valid_q <= (state_d == S_PEND);
    end
  end

  // Payload storage; contents are only observable through the read pointer.
  always_ff @(posedge sys_clk) begin
    if (buf_we) buf_q[wr_ptr_q[PTR_W-1:0]] <= rx_data;
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_wr      = wr_q;
  assign cmd_addr    = addr_q;
  assign cmd_len     = len_q;
  assign wdata       = buf_q[rd_ptr_q[PTR_W-1:0]];
  assign wdata_empty = !can_pop;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule
